// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: sequential instruction prefetch FIFO between the
// core fetch port and instruction memory. Both sides use req/gnt/rvalid.
// The optional hit/redirect statistics counters are enabled by defining the
// PFB_STATS_EN macro.
module instr_prefetch_buffer #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        core_req,
    input  logic [31:0] core_addr,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic [31:0] core_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
`ifdef PFB_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_redirects
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]        pf_addr_q, pf_addr_d;
    logic               outstanding_q, outstanding_d;
    logic [31:0]        pend_addr_q, pend_addr_d;
    logic               rvalid_q, rvalid_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        fifo_addr_q [DEPTH];
    logic [31:0]        fifo_data_q [DEPTH];

    logic [31:0]        head_addr_s;
    logic [31:0]        head_data_s;
    logic [31:0]        exp_addr_s;
    logic [CNT_W:0]     occ_s;
    logic               room_s;
    logic               redirect_s;
    logic               hit_s;
    logic               push_s;
    logic               issue_s;
    logic               mem_req_s;
    logic [31:0]        mem_addr_s;

    // Classify the core request (hit / wait / redirect) and derive the memory request.
    always_comb begin
        head_addr_s = fifo_addr_q[rd_ptr_q];
        head_data_s = fifo_data_q[rd_ptr_q];
        if (count_q != CNT_W'(0)) begin
            exp_addr_s = head_addr_s;
        end else if (outstanding_q) begin
            exp_addr_s = pend_addr_q;
        end else begin
            exp_addr_s = pf_addr_q;
        end
        // Occupancy uses count before this cycle's pop, so no look-ahead.
        occ_s      = {1'b0, count_q} + {{CNT_W{1'b0}}, outstanding_q};
        room_s     = (occ_s < (CNT_W+1)'(DEPTH));
        redirect_s = core_req && ((state_q == ST_IDLE) || (core_addr != exp_addr_s));
        hit_s      = core_req && !redirect_s && (count_q != CNT_W'(0));
        // A response only belongs to us if a grant preceded it; a redirect makes it stale.
        push_s     = mem_rvalid && outstanding_q && !redirect_s;
        if (redirect_s) begin
            mem_req_s  = 1'b1;
            mem_addr_s = core_addr;
        end else if (state_q == ST_STREAM) begin
            mem_req_s  = room_s;
            mem_addr_s = pf_addr_q;
        end else begin
            mem_req_s  = 1'b0;
            mem_addr_s = pf_addr_q;
        end
        issue_s = mem_req_s && mem_gnt;
    end

    // Next-state for FSM, FIFO bookkeeping, prefetch address and core response.
    always_comb begin
        case (state_q)
            ST_IDLE:   state_d = core_req ? ST_STREAM : ST_IDLE;
            ST_STREAM: state_d = ST_STREAM;
            default:   state_d = ST_IDLE;
        endcase
        outstanding_d = issue_s;
        pend_addr_d   = issue_s ? mem_addr_s : pend_addr_q;
        if (redirect_s) begin
            pf_addr_d = mem_gnt ? (core_addr + 32'd4) : core_addr;
        end else if (issue_s) begin
            pf_addr_d = pf_addr_q + 32'd4;
        end else begin
            pf_addr_d = pf_addr_q;
        end
        if (redirect_s) begin
            count_d  = CNT_W'(0);
            rd_ptr_d = PTR_W'(0);
            wr_ptr_d = PTR_W'(0);
        end else begin
            rd_ptr_d = hit_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
            wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
            case ({push_s, hit_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        rvalid_d = hit_s;
        rdata_d  = hit_s ? head_data_s : 32'h0000_0000;
    end

    // Control and response registers with asynchronous reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q       <= ST_IDLE;
            count_q       <= CNT_W'(0);
            rd_ptr_q      <= PTR_W'(0);
            wr_ptr_q      <= PTR_W'(0);
            pf_addr_q     <= BOOT_ADDR;
            outstanding_q <= 1'b0;
            pend_addr_q   <= BOOT_ADDR;
            rvalid_q      <= 1'b0;
            rdata_q       <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            pf_addr_q     <= pf_addr_d;
            outstanding_q <= outstanding_d;
            pend_addr_q   <= pend_addr_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
        end
    end

    // FIFO storage: write {fetch address, word} at the tail on a push.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_addr_q[i] <= 32'h0000_0000;
                fifo_data_q[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            fifo_addr_q[wr_ptr_q] <= pend_addr_q;
            fifo_data_q[wr_ptr_q] <= mem_rdata;
        end else begin
            fifo_addr_q[wr_ptr_q] <= fifo_addr_q[wr_ptr_q];
            fifo_data_q[wr_ptr_q] <= fifo_data_q[wr_ptr_q];
        end
    end

    assign core_gnt    = hit_s;
    assign core_rvalid = rvalid_q;
    assign core_rdata  = rdata_q;
    assign mem_req     = mem_req_s;
    assign mem_addr    = mem_addr_s;

`ifdef PFB_STATS_EN
    logic [31:0] hits_q, hits_d;
    logic [31:0] redir_q, redir_d;

    // Saturating statistics counters.
    always_comb begin
        hits_d  = (hit_s && (hits_q != 32'hFFFF_FFFF)) ? (hits_q + 32'd1) : hits_q;
        redir_d = (redirect_s && (redir_q != 32'hFFFF_FFFF)) ? (redir_q + 32'd1) : redir_q;
    end

    // Statistics registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hits_q  <= 32'h0000_0000;
            redir_q <= 32'h0000_0000;
        end else begin
            hits_q  <= hits_d;
            redir_q <= redir_d;
        end
    end

    assign stat_hits      = hits_q;
    assign stat_redirects = redir_q;
`endif

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed testbench for instr_prefetch_buffer with a one-cycle-latency
// memory responder built into the cycle-advance task.
module tb_instr_prefetch_buffer;

    localparam int unsigned DEPTH = 4;

    logic        HCLK;
    logic        HRESETn;
    logic        core_req;
    logic [31:0] core_addr;
    logic        core_gnt;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
`ifdef PFB_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_redirects;
`endif

    int tests;
    int fails;

    instr_prefetch_buffer #(.DEPTH(DEPTH), .BOOT_ADDR(32'h0000_0000)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .core_req    (core_req),
        .core_addr   (core_addr),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
`ifdef PFB_STATS_EN
        ,
        .stat_hits      (stat_hits),
        .stat_redirects (stat_redirects)
`endif
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the memory answers a granted request one cycle later.
    task automatic cyc();
        logic        g;
        logic [31:0] a;
        g = mem_req & mem_gnt;
        a = mem_addr;
        @(posedge HCLK);
        #1;
        mem_rvalid = g;
        mem_rdata  = g ? word(a) : 32'h0000_0000;
    endtask

    task automatic drive(input logic req, input logic [31:0] addr);
        core_req  = req;
        core_addr = addr;
        #1;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        HRESETn    = 1'b0;
        core_req   = 1'b0;
        core_addr  = 32'h0;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        #2;
        chk1 ("rst_gnt",    core_gnt,    1'b0);
        chk1 ("rst_rvalid", core_rvalid, 1'b0);
        chk32("rst_rdata",  core_rdata,  32'h0);
        chk1 ("rst_mreq",   mem_req,     1'b0);
        chk32("rst_maddr",  mem_addr,    32'h0);
        cyc(); cyc();
        HRESETn = 1'b1;

        // First fetch from reset: request same cycle, gnt at +2, rvalid at +3.
        drive(1'b1, 32'h0);
        chk1 ("t1_mreq",  mem_req,  1'b1);
        chk32("t1_maddr", mem_addr, 32'h0);
        chk1 ("t1_gnt0",  core_gnt, 1'b0);
        cyc();
        drive(1'b1, 32'h0);
        chk1 ("t1_wait",   core_gnt, 1'b0);
        chk32("t1_maddr4", mem_addr, 32'h4);
        cyc();
        drive(1'b1, 32'h0);
        chk1 ("t1_gnt",     core_gnt,    1'b1);
        chk1 ("t1_rvalid0", core_rvalid, 1'b0);
        cyc();

        // Sequential stream 0x4..0x3C: one grant per cycle, data in order.
        for (int i = 1; i < 16; i++) begin
            drive(1'b1, 32'(4 * i));
            chk1 ("t2_gnt",    core_gnt,    1'b1);
            chk1 ("t2_rvalid", core_rvalid, 1'b1);
            chk32("t2_rdata",  core_rdata,  word(32'(4 * (i - 1))));
            chk32("t2_maddr",  mem_addr,    32'(4 * (i + 2)));
            chk1 ("t2_lead",   (mem_addr - core_addr) <= 32'((DEPTH + 1) * 4), 1'b1);
            cyc();
        end

        // Core idle: buffer fills to DEPTH and stops requesting.
        drive(1'b0, 32'h0);
        chk1 ("t4_rvalid", core_rvalid, 1'b1);
        chk32("t4_rdata",  core_rdata,  word(32'h3C));
        cyc();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 32'h0);
            cyc();
        end
        drive(1'b0, 32'h0);
        chk1 ("t4_full_mreq",  mem_req,  1'b0);
        chk32("t4_full_maddr", mem_addr, 32'h50);
        cyc();
        drive(1'b1, 32'h40);
        chk1 ("t4_hit0",  core_gnt, 1'b1);
        chk1 ("t4_nolook", mem_req, 1'b0);
        cyc();
        drive(1'b1, 32'h44);
        chk1 ("t4_hit1",   core_gnt,   1'b1);
        chk32("t4_rd0",    core_rdata, word(32'h40));
        chk1 ("t4_mreq1",  mem_req,    1'b1);
        chk32("t4_maddr1", mem_addr,   32'h50);
        cyc();
        drive(1'b1, 32'h48);
        chk1 ("t4_hit2", core_gnt,   1'b1);
        chk32("t4_rd1",  core_rdata, word(32'h44));
        cyc();
        drive(1'b1, 32'h4C);
        chk1 ("t4_hit3", core_gnt,   1'b1);
        chk32("t4_rd2",  core_rdata, word(32'h48));
        cyc();

        // Redirect mid-stream to 0x10; the in-flight response is stale.
        drive(1'b1, 32'h10);
        chk1 ("t3a_gnt0",  core_gnt,   1'b0);
        chk1 ("t3a_mreq",  mem_req,    1'b1);
        chk32("t3a_maddr", mem_addr,   32'h10);
        chk32("t3a_rd3",   core_rdata, word(32'h4C));
        cyc();
        drive(1'b1, 32'h10);
        chk1 ("t3a_wait",    core_gnt,    1'b0);
        chk1 ("t3a_rvalid0", core_rvalid, 1'b0);
        chk32("t3a_maddr14", mem_addr,    32'h14);
        cyc();
        drive(1'b1, 32'h10);
        chk1 ("t3a_gnt", core_gnt, 1'b1);
        cyc();
        drive(1'b0, 32'h0);
        chk1 ("t3a_rvalid", core_rvalid, 1'b1);
        chk32("t3a_rdata",  core_rdata,  word(32'h10));
        cyc();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0);
            cyc();
        end
        drive(1'b0, 32'h0);
        chk1 ("t3b_full_mreq",  mem_req,  1'b0);
        chk32("t3b_full_maddr", mem_addr, 32'h24);
        cyc();

        // Redirect from a full buffer to 0x100.
        drive(1'b1, 32'h100);
        chk1 ("t3b_mreq",  mem_req,  1'b1);
        chk32("t3b_maddr", mem_addr, 32'h100);
        chk1 ("t3b_gnt0",  core_gnt, 1'b0);
        cyc();
        drive(1'b1, 32'h100);
        chk1 ("t3b_wait",    core_gnt,    1'b0);
        chk1 ("t3b_rvalid0", core_rvalid, 1'b0);
        chk32("t3b_maddr4",  mem_addr,    32'h104);
        cyc();
        drive(1'b1, 32'h100);
        chk1 ("t3b_gnt", core_gnt, 1'b1);
        cyc();

        // Memory stalls grant for three cycles.
        mem_gnt = 1'b0;
        drive(1'b0, 32'h0);
        chk1 ("t3b_rvalid", core_rvalid, 1'b1);
        chk32("t3b_rdata",  core_rdata,  word(32'h100));
        chk1 ("t5_mreq0",   mem_req,     1'b1);
        chk32("t5_maddr0",  mem_addr,    32'h10C);
        cyc();
        for (int i = 1; i < 3; i++) begin
            drive(1'b0, 32'h0);
            chk1 ("t5_mreq_hold",  mem_req,  1'b1);
            chk32("t5_maddr_hold", mem_addr, 32'h10C);
            cyc();
        end
        mem_gnt = 1'b1;
        drive(1'b0, 32'h0);
        chk32("t5_maddr_rel", mem_addr, 32'h10C);
        cyc();
        drive(1'b0, 32'h0);
        chk32("t5_maddr_next", mem_addr, 32'h110);
        cyc();
        drive(1'b1, 32'h104);
        chk1 ("t5_hit0", core_gnt, 1'b1);
        cyc();
        drive(1'b1, 32'h108);
        chk1 ("t5_hit1", core_gnt,   1'b1);
        chk32("t5_rd0",  core_rdata, word(32'h104));
        cyc();
        drive(1'b1, 32'h10C);
        chk1 ("t5_hit2", core_gnt,   1'b1);
        chk32("t5_rd1",  core_rdata, word(32'h108));
        cyc();
        drive(1'b1, 32'h110);
        chk1 ("t5_hit3", core_gnt,   1'b1);
        chk32("t5_rd2",  core_rdata, word(32'h10C));
        cyc();

        // Redirect near the top of the address space; address wraps to 0.
        drive(1'b1, 32'hFFFF_FFF8);
        chk1 ("t6_gnt0",  core_gnt,   1'b0);
        chk1 ("t6_mreq",  mem_req,    1'b1);
        chk32("t6_maddr", mem_addr,   32'hFFFF_FFF8);
        chk32("t6_rd3",   core_rdata, word(32'h110));
        cyc();
        drive(1'b1, 32'hFFFF_FFF8);
        chk1 ("t6_wait",    core_gnt, 1'b0);
        chk32("t6_maddrFC", mem_addr, 32'hFFFF_FFFC);
        cyc();
        drive(1'b1, 32'hFFFF_FFF8);
        chk1 ("t6_gnt",     core_gnt,    1'b1);
        chk1 ("t6_rvalid0", core_rvalid, 1'b0);
        chk32("t6_wrap",    mem_addr,    32'h0);
        cyc();
        drive(1'b1, 32'hFFFF_FFFC);
        chk1 ("t6_hitFC",  core_gnt,   1'b1);
        chk32("t6_rdF8",   core_rdata, word(32'hFFFF_FFF8));
        chk32("t6_maddr4", mem_addr,   32'h4);
        cyc();
        drive(1'b1, 32'h0);
        chk1 ("t6_hit0", core_gnt,   1'b1);
        chk32("t6_rdFC", core_rdata, word(32'hFFFF_FFFC));
        cyc();
        drive(1'b1, 32'h4);
        chk32("t6_rd0",    core_rdata,  word(32'h0));
        chk1 ("t6_rvalid", core_rvalid, 1'b1);

        // Asynchronous reset mid-stream: outputs clear without a clock edge.
        #1;
        HRESETn  = 1'b0;
        core_req = 1'b0;
        #1;
        chk1 ("ar_gnt",    core_gnt,    1'b0);
        chk1 ("ar_rvalid", core_rvalid, 1'b0);
        chk32("ar_rdata",  core_rdata,  32'h0);
        chk1 ("ar_mreq",   mem_req,     1'b0);
        chk32("ar_maddr",  mem_addr,    32'h0);
        cyc();
        HRESETn    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        drive(1'b0, 32'h0);
        chk1 ("ar_idle_mreq", mem_req,     1'b0);
        chk1 ("ar_idle_rv",   core_rvalid, 1'b0);
        cyc();
        drive(1'b1, 32'h20);
        chk1 ("ar_mreq",  mem_req,  1'b1);
        chk32("ar_maddr20", mem_addr, 32'h20);
        chk1 ("ar_gnt0",  core_gnt, 1'b0);
        cyc();
        drive(1'b1, 32'h20);
        chk1 ("ar_wait", core_gnt, 1'b0);
        cyc();
        drive(1'b1, 32'h20);
        chk1 ("ar_gnt", core_gnt, 1'b1);
        cyc();
        drive(1'b0, 32'h0);
        chk1 ("ar_rvalid1", core_rvalid, 1'b1);
        chk32("ar_rdata20", core_rdata,  word(32'h20));
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
